// File: rtl/shift_add_mac.sv
// Iterative shift-add multiply-accumulate: consumes BITS_PER_CYCLE multiplier bits per
// clock, with per-operand signedness, ready/valid on both sides and a sticky-overflow accumulator.
module shift_add_mac #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4,
  parameter int ACC_WIDTH      = 2*WIDTH+8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic                   a_signed,
  input  logic                   b_signed,
  input  logic                   accumulate,
  input  logic                   clear_acc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   overflow,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int PW = 2*WIDTH;
  localparam int N  = WIDTH/BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a transfer happens on any rising clk edge where valid and ready are
  // both high; out_valid and the result stay stable until that edge.
  logic [1:0]           state;
  logic [PW-1:0]        a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic                 a_s_q, b_s_q, acc_mode_q;
  logic [PW-1:0]        pp, pp_next;
  logic [CW-1:0]        cnt;
  logic                 finish;
  logic [ACC_WIDTH-1:0] prod_ext, base, sum;
  logic                 add_ovf;

  assign in_ready  = (state == S_IDLE);
  assign state_dbg = state;
  assign finish    = (state == S_RUN) && (cnt == LAST);

  // a_sh is pre-shifted each cycle, so only constant shifts are needed here.
  always_comb begin
    pp_next = pp;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_sh[j]) begin
        if (b_s_q && (cnt == LAST) && (j == BITS_PER_CYCLE-1))
          pp_next = pp_next - (a_sh << j);
        else
          pp_next = pp_next + (a_sh << j);
      end
    end
  end

  always_comb begin
    prod_ext = (a_s_q | b_s_q) ? ACC_WIDTH'($signed(pp_next)) : ACC_WIDTH'(pp_next);
    base     = (acc_mode_q && !clear_acc) ? acc : '0;
    sum      = base + prod_ext;
    add_ovf  = (base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      a_s_q      <= 1'b0;
      b_s_q      <= 1'b0;
      acc_mode_q <= 1'b0;
      pp         <= '0;
      cnt        <= '0;
      product    <= '0;
      acc        <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (clear_acc && !finish) begin
        acc      <= '0;
        overflow <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh       <= a_signed ? PW'($signed(A)) : PW'(A);
            b_sh       <= B;
            a_s_q      <= a_signed;
            b_s_q      <= b_signed;
            acc_mode_q <= accumulate;
            pp         <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          pp   <= pp_next;
          a_sh <= a_sh << BITS_PER_CYCLE;
          b_sh <= b_sh >> BITS_PER_CYCLE;
          cnt  <= cnt + 1'b1;
          if (finish) begin
            product   <= pp_next;
            acc       <= sum;
            overflow  <= (overflow & ~clear_acc) | add_ovf;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mac.sv
// Directed bench for shift_add_mac: vector table plus backpressure, overflow and
// mid-operation reset sequences. A 32-bit-accumulator instance shares the stimulus.
module tb_shift_add_mac;

  logic        clk, rst;
  logic        in_valid, out_ready, clear_acc;
  logic [15:0] a_in, b_in;
  logic        a_signed, b_signed, accumulate;

  logic        in_ready, out_valid, overflow, busy;
  logic [31:0] product;
  logic [39:0] acc;
  logic [1:0]  state_dbg;

  logic        in_ready_w, out_valid_w, overflow_w, busy_w;
  logic [31:0] product_w;
  logic [31:0] acc_w;
  logic [1:0]  state_dbg_w;

  int checks = 0;
  int errors = 0;

  shift_add_mac u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .a_signed(a_signed), .b_signed(b_signed),
    .accumulate(accumulate), .clear_acc(clear_acc), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .acc(acc), .overflow(overflow),
    .busy(busy), .state_dbg(state_dbg)
  );

  shift_add_mac #(.WIDTH(16), .BITS_PER_CYCLE(4), .ACC_WIDTH(32)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(a_in), .B(b_in), .a_signed(a_signed), .b_signed(b_signed),
    .accumulate(accumulate), .clear_acc(clear_acc), .out_valid(out_valid_w),
    .out_ready(out_ready), .product(product_w), .acc(acc_w), .overflow(overflow_w),
    .busy(busy_w), .state_dbg(state_dbg_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        pre_clear;
    logic [15:0] a;
    logic [15:0] b;
    logic        as_;
    logic        bs;
    logic        accum;
    logic [31:0] exp_prod;
    logic [39:0] exp_acc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_acc = 1'b1;
    @(negedge clk);
    clear_acc = 1'b0;
  endtask

  // Issues one operation and returns cycles from acceptance to out_valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tas,
                       input logic tbs, input logic tacc, output int lat, output logic busy_ok);
    int n;
    @(negedge clk);
    a_in = ta; b_in = tb; a_signed = tas; b_signed = tbs; accumulate = tacc;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        bok;
    int          n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_acc = 1'b0;
    a_in = '0; b_in = '0; a_signed = 1'b0; b_signed = 1'b0; accumulate = 1'b0;

    vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001, 40'h00FFFE0001};
    vecs[1] = '{1'b0, 16'hFFFB, 16'h000A, 1'b1, 1'b0, 1'b0, 32'hFFFFFFCE, 40'hFFFFFFFFCE};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF0001, 40'hFFFFFF0001};
    vecs[3] = '{1'b0, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 32'h40000000, 40'h0040000000};
    vecs[4] = '{1'b1, 16'h000A, 16'h0005, 1'b0, 1'b0, 1'b1, 32'h00000032, 40'h0000000032};
    vecs[5] = '{1'b0, 16'h0007, 16'hFFF8, 1'b1, 1'b1, 1'b1, 32'hFFFFFFC8, 40'hFFFFFFFFFA};
    vecs[6] = '{1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h00000009, 40'h0000000009};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_product", {32'd0, product}, 64'd0);
    check("rst_acc", {24'd0, acc}, 64'd0);
    check("rst_acc_w", {32'd0, acc_w}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_clear) begin
        pulse_clear();
        check($sformatf("v%0d_clear_acc", i), {24'd0, acc}, 64'd0);
      end
      do_op(vecs[i].a, vecs[i].b, vecs[i].as_, vecs[i].bs, vecs[i].accum, lat, bok);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("v%0d_busy_run", i), {63'd0, bok}, 64'd1);
      check($sformatf("v%0d_product", i), {32'd0, product}, {32'd0, vecs[i].exp_prod});
      check($sformatf("v%0d_acc", i), {24'd0, acc}, {24'd0, vecs[i].exp_acc});
      finish_op();
      check($sformatf("v%0d_idle", i), {63'd0, in_ready}, 64'd1);
    end

    // backpressure: result held, in_valid ignored while DONE
    do_op(16'h1234, 16'h0002, 1'b0, 1'b0, 1'b0, lat, bok);
    check("bp_latency", 64'(lat), 64'd4);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_product_%0d", k), {32'd0, product}, 64'h2468);
      check($sformatf("bp_acc_%0d", k), {24'd0, acc}, 64'h2468);
      check($sformatf("bp_in_ready_%0d", k), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp_out_valid_%0d", k), {63'd0, out_valid}, 64'd1);
      if (k == 1) begin
        a_in = 16'h0005; b_in = 16'h0005; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("bp_no_queue_busy", {63'd0, busy}, 64'd0);

    // overflow on the 32-bit-accumulator instance
    pulse_clear();
    do_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, lat, bok);
    check("ov1_acc_w", {32'd0, acc_w}, 64'h40000000);
    check("ov1_overflow_w", {63'd0, overflow_w}, 64'd0);
    finish_op();
    do_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, lat, bok);
    check("ov2_acc_w", {32'd0, acc_w}, 64'h80000000);
    check("ov2_overflow_w", {63'd0, overflow_w}, 64'd1);
    check("ov2_acc_wide", {24'd0, acc}, 64'h80000000);
    check("ov2_overflow_wide", {63'd0, overflow}, 64'd0);
    finish_op();
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, lat, bok);
    check("ov3_acc_w", {32'd0, acc_w}, 64'h80000001);
    check("ov3_sticky", {63'd0, overflow_w}, 64'd1);
    finish_op();
    pulse_clear();
    check("ov_clear_acc_w", {32'd0, acc_w}, 64'd0);
    check("ov_clear_overflow_w", {63'd0, overflow_w}, 64'd0);

    // reset two cycles after acceptance
    pulse_clear();
    do_op(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, lat, bok);
    finish_op();
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; a_signed = 1'b0; b_signed = 1'b0; accumulate = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_run_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_acc", {24'd0, acc}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, lat, bok);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_product", {32'd0, product}, 64'h0000FE01);
    check("post_rst_acc", {24'd0, acc}, 64'h0000FE01);
    finish_op();

    n = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
